// File: rtl/fir_csm_mac_sequencer.sv
// Time-multiplexed FIR MAC: one shared odd-multiple precomputer (x1..x15),
// one (tap, nibble) step per cycle. Optional macro FIR_CSM_SAT_EN saturates the result.
module fir_csm_mac_sequencer #(
    parameter int IN_DATA_WIDTH = 17,
    parameter int PC_DATA_WIDTH = 21,
    parameter int COEF_WIDTH    = 16,
    parameter int NUM_TAPS      = 8,
    parameter int ACC_WIDTH     = 40,
    parameter int RESULT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [IN_DATA_WIDTH-1:0]      in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [RESULT_WIDTH-1:0]       out_data,
    output logic                          out_sat,
    output logic                          busy,
    input  logic                          coef_wr_en,
    input  logic [$clog2(NUM_TAPS)-1:0]   coef_wr_addr,
    input  logic [COEF_WIDTH-1:0]         coef_wr_data
);

    localparam int NIBS  = COEF_WIDTH / 4;
    localparam int TAP_W = $clog2(NUM_TAPS);
    localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_reg, state_next;
    logic                       accept, step_en, last_step, coef_we, addr_ok;
    logic [IN_DATA_WIDTH-1:0]   delay_reg [NUM_TAPS];
    logic [COEF_WIDTH-1:0]      coef_reg  [NUM_TAPS];
    logic [ACC_WIDTH-1:0]       acc_reg, acc_next, term;
    logic [TAP_W-1:0]           tap_reg;
    logic [NIB_W-1:0]           nib_reg;
    logic                       out_valid_reg, out_sat_reg, res_sat;
    logic [RESULT_WIDTH-1:0]    out_data_reg, res_data;

    logic [IN_DATA_WIDTH-1:0]   cur_x;
    logic [PC_DATA_WIDTH-1:0]   odd_mult [8];
    logic [3:0]                 nib_val;
    logic [2:0]                 odd_idx;
    logic [1:0]                 pow_k;

    // Shared precomputer: odd_mult[gi] = (2*gi+1) * current tap sample.
    assign cur_x = delay_reg[tap_reg];
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_odd
            assign odd_mult[gi] = PC_DATA_WIDTH'(cur_x) * PC_DATA_WIDTH'(2 * gi + 1);
        end
    endgenerate

    // Only needed when the address field can encode taps that do not exist.
    generate
        if ((1 << TAP_W) > NUM_TAPS) begin : g_addr_chk
            assign addr_ok = ({1'b0, coef_wr_addr} < (TAP_W + 1)'(NUM_TAPS));
        end else begin : g_addr_all
            assign addr_ok = 1'b1;
        end
    endgenerate

    assign nib_val = coef_reg[tap_reg][4 * nib_reg +: 4];

    // Split the nibble n into m * 2^k with m odd; odd_idx selects x_m.
    always_comb begin
        odd_idx = 3'd0;
        pow_k   = 2'd0;
        case (nib_val)
            4'd1:  begin odd_idx = 3'd0; pow_k = 2'd0; end
            4'd2:  begin odd_idx = 3'd0; pow_k = 2'd1; end
            4'd3:  begin odd_idx = 3'd1; pow_k = 2'd0; end
            4'd4:  begin odd_idx = 3'd0; pow_k = 2'd2; end
            4'd5:  begin odd_idx = 3'd2; pow_k = 2'd0; end
            4'd6:  begin odd_idx = 3'd1; pow_k = 2'd1; end
            4'd7:  begin odd_idx = 3'd3; pow_k = 2'd0; end
            4'd8:  begin odd_idx = 3'd0; pow_k = 2'd3; end
            4'd9:  begin odd_idx = 3'd4; pow_k = 2'd0; end
            4'd10: begin odd_idx = 3'd2; pow_k = 2'd1; end
            4'd11: begin odd_idx = 3'd5; pow_k = 2'd0; end
            4'd12: begin odd_idx = 3'd1; pow_k = 2'd2; end
            4'd13: begin odd_idx = 3'd6; pow_k = 2'd0; end
            4'd14: begin odd_idx = 3'd3; pow_k = 2'd1; end
            4'd15: begin odd_idx = 3'd7; pow_k = 2'd0; end
            default: begin odd_idx = 3'd0; pow_k = 2'd0; end
        endcase
    end

    always_comb begin
        term = '0;
        if (nib_val != 4'd0) begin
            term = ACC_WIDTH'(odd_mult[odd_idx]) << (int'(pow_k) + 4 * int'(nib_reg));
        end
    end

    assign acc_next = acc_reg + term;

`ifdef FIR_CSM_SAT_EN
    always_comb begin
        res_data = acc_next[RESULT_WIDTH-1:0];
        res_sat  = 1'b0;
        if (|acc_next[ACC_WIDTH-1:RESULT_WIDTH]) begin
            res_data = '1;
            res_sat  = 1'b1;
        end
    end
`else
    assign res_data = acc_next[RESULT_WIDTH-1:0];
    assign res_sat  = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        step_en    = 1'b0;
        last_step  = (tap_reg == TAP_W'(NUM_TAPS - 1)) && (nib_reg == NIB_W'(NIBS - 1));
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign coef_we = coef_wr_en && (state_reg == IDLE) && addr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                delay_reg[i] <= '0;
                coef_reg[i]  <= '0;
            end
            acc_reg       <= '0;
            tap_reg       <= '0;
            nib_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sat_reg   <= 1'b0;
        end else begin
            // A write landing on the accept edge is seen by the new sample,
            // since coefficients are only read from the following cycle on.
            if (coef_we) begin
                coef_reg[coef_wr_addr] <= coef_wr_data;
            end
            if (accept) begin
                delay_reg[0] <= in_data;
                for (int i = 1; i < NUM_TAPS; i++) begin
                    delay_reg[i] <= delay_reg[i-1];
                end
                acc_reg <= '0;
                tap_reg <= '0;
                nib_reg <= '0;
            end
            if (step_en) begin
                acc_reg <= acc_next;
                if (nib_reg == NIB_W'(NIBS - 1)) begin
                    nib_reg <= '0;
                    tap_reg <= tap_reg + 1'b1;
                end else begin
                    nib_reg <= nib_reg + 1'b1;
                end
                if (last_step) begin
                    out_valid_reg <= 1'b1;
                    out_data_reg  <= res_data;
                    out_sat_reg   <= res_sat;
                end
            end
            if ((state_reg == DONE) && out_ready) begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_fir_csm_mac_sequencer.sv
// Self-checking bench: directed scenarios plus random samples against a
// sum-of-products reference model of the filter.
module tb_fir_csm_mac_sequencer;

    localparam int IW = 17;
    localparam int CW = 16;
    localparam int NT = 8;
    localparam int RW = 32;
    localparam int LATENCY = NT * CW / 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [IW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_data;
    logic          out_sat;
    logic          busy;
    logic          coef_wr_en;
    logic [2:0]    coef_wr_addr;
    logic [CW-1:0] coef_wr_data;

    fir_csm_mac_sequencer #(
        .IN_DATA_WIDTH(IW), .PC_DATA_WIDTH(IW + 4), .COEF_WIDTH(CW),
        .NUM_TAPS(NT), .ACC_WIDTH(40), .RESULT_WIDTH(RW)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sat(out_sat), .busy(busy),
        .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;
    longint unsigned m_delay [NT];
    longint unsigned m_coef  [NT];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NT; i++) begin
            m_delay[i] = 0;
            m_coef[i]  = 0;
        end
    endtask

    task automatic model_result(output logic [RW-1:0] d, output logic s);
        longint unsigned sum = 0;
        for (int i = 0; i < NT; i++) sum += m_coef[i] * m_delay[i];
`ifdef FIR_CSM_SAT_EN
        if ((sum >> RW) != 0) begin
            d = '1;
            s = 1'b1;
        end else begin
            d = RW'(sum);
            s = 1'b0;
        end
`else
        d = RW'(sum);
        s = 1'b0;
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; coef_wr_en = 1'b0;
        in_data = '0; coef_wr_addr = '0; coef_wr_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        model_clear();
        #1;
        check("rst_in_ready", in_ready, 1);
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [CW-1:0] v);
        coef_wr_en = 1'b1; coef_wr_addr = a; coef_wr_data = v;
        @(posedge clk);
        #1;
        coef_wr_en = 1'b0;
        m_coef[a] = v;
    endtask

    task automatic accept_sample(input logic [IW-1:0] d, input bit wr_acc,
                                 input logic [2:0] wa, input logic [CW-1:0] wd);
        check("in_ready_idle", in_ready, 1);
        in_data = d; in_valid = 1'b1;
        if (wr_acc) begin
            coef_wr_en = 1'b1; coef_wr_addr = wa; coef_wr_data = wd;
            m_coef[wa] = wd;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0; coef_wr_en = 1'b0;
        for (int i = NT - 1; i > 0; i--) m_delay[i] = m_delay[i-1];
        m_delay[0] = d;
    endtask

    task automatic run_sample(input logic [IW-1:0] d, input int hold, input bit wr_hold,
                              input bit wr_acc, input logic [2:0] wa, input logic [CW-1:0] wd);
        logic [RW-1:0] ed;
        logic es;
        int lat;
        accept_sample(d, wr_acc, wa, wd);
        model_result(ed, es);
        check("busy_run", busy, 1);
        check("in_ready_run", in_ready, 0);
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
        check("latency", lat, LATENCY);
        check("out_data", out_data, ed);
        check("out_sat", out_sat, es);
        for (int h = 0; h < hold; h++) begin
            if (wr_hold) begin
                coef_wr_en = 1'b1; coef_wr_addr = wa; coef_wr_data = ~wd;
            end
            @(posedge clk);
            #1;
            coef_wr_en = 1'b0;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, ed);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_valid", out_valid, 0);
        check("post_in_ready", in_ready, 1);
        txn++;
        $display("txn %0d: in=0x%0h out=0x%0h sat=%0d expected=0x%0h/%0d latency=%0d",
                 txn, d, out_data, out_sat, ed, es, lat);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        do_reset();

        // Single tap, unit coefficient
        write_coef(3'd0, 16'd1);
        run_sample(17'd5, 0, 1'b0, 1'b0, 3'd0, 16'd0);
        // Even nibbles through shifted x1
        write_coef(3'd0, 16'h8421);
        run_sample(17'd3, 0, 1'b0, 1'b0, 3'd0, 16'd0);

        // Delay-line shift
        do_reset();
        write_coef(3'd0, 16'd1);
        write_coef(3'd1, 16'd2);
        run_sample(17'd10, 0, 1'b0, 1'b0, 3'd0, 16'd0);
        run_sample(17'd20, 0, 1'b0, 1'b0, 3'd0, 16'd0);

        // Widest product: truncation or saturation
        write_coef(3'd0, 16'hFFFF);
        write_coef(3'd1, 16'h0000);
        run_sample(17'h1FFFF, 0, 1'b0, 1'b0, 3'd0, 16'd0);

        // Long DONE hold with ignored writes, then a result that exposes any leak
        write_coef(3'd0, 16'h0003);
        run_sample(17'h00123, 5, 1'b1, 1'b0, 3'd0, 16'h0003);
        run_sample(17'h00777, 0, 1'b0, 1'b0, 3'd0, 16'd0);

        // Write on the accept edge is used by that sample
        run_sample(17'h0ABCD, 0, 1'b0, 1'b1, 3'd0, 16'h5A3C);

        // Reset in the middle of RUN
        accept_sample(17'h1F00F, 1'b0, 3'd0, 16'd0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        #1;
        check("abort_in_ready", in_ready, 1);
        run_sample(17'd7, 0, 1'b0, 1'b0, 3'd0, 16'd0);

        // Randomised traffic
        for (int t = 0; t < 24; t++) begin
            int nw;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++) begin
                write_coef(3'($urandom_range(0, NT - 1)), 16'($urandom));
            end
            run_sample(17'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 3'($urandom_range(0, NT - 1)), 16'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
